// File: rtl/testcore_reset_seq.sv
// Power-on / PLL-lock reset sequencer ahead of the Nios II test core.
// Ports: clk, reset, pll_locked, sw_reset_req -> core_reset_n, adc_locked_out, running, lock_loss_cnt.
module testcore_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 64,
  parameter int LOSS_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  core_reset_n,
  output logic                  adc_locked_out,
  output logic                  running,
  output logic [LOSS_WIDTH-1:0] lock_loss_cnt
);

  localparam int MAXC =
    (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    HOLD,
    RUN
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic [TW-1:0]          timer, timer_next;
  logic [LOSS_WIDTH-1:0]  cnt_next;
  logic                   core_reset_n_next;
  logic                   adc_locked_next;
  logic                   running_next;

  assign lock_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync           <= '0;
      state          <= WAIT_LOCK;
      timer          <= '0;
      core_reset_n   <= 1'b0;
      adc_locked_out <= 1'b0;
      running        <= 1'b0;
      lock_loss_cnt  <= '0;
    end else begin
      sync           <= {sync[SYNC_STAGES-2:0], pll_locked};
      state          <= state_next;
      timer          <= timer_next;
      core_reset_n   <= core_reset_n_next;
      adc_locked_out <= adc_locked_next;
      running        <= running_next;
      lock_loss_cnt  <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    cnt_next   = lock_loss_cnt;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = STABILIZE;
          timer_next = '0;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end else if (timer == STABLE_LAST) begin
          state_next = HOLD;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end else if (timer == HOLD_LAST) begin
          state_next = RUN;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      RUN: begin
        // Lock loss has priority over a software re-hold request.
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
          if (lock_loss_cnt != '1) begin
            cnt_next = lock_loss_cnt + LOSS_WIDTH'(1);
          end
        end else if (sw_reset_req) begin
          state_next = HOLD;
          timer_next = '0;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_comb begin
    core_reset_n_next = (state_next == RUN);
    running_next      = (state_next == RUN);
    adc_locked_next   = (state_next == HOLD) || (state_next == RUN);
  end

endmodule
